// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - shared types for the refill read arbiter
package wt_cache_pkg;

    localparam int unsigned RdIdWidth   = 4;
    localparam int unsigned RdBlenWidth = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } refill_arb_state_e;

    typedef struct packed {
        logic [63:0]            addr;
        logic [RdBlenWidth-1:0] blen;
        logic [1:0]             size;
        logic [RdIdWidth-1:0]   id;
    } rd_req_t;

endpackage

// File: rtl/refill_rr_pick.sv
// rtl/refill_rr_pick.sv - first asserted request at or after a pointer, wrapping
module refill_rr_pick #(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    always_comb begin
        int j;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < int'(NumReq); k++) begin
            j = int'(ptr_i) + k;
            if (j >= int'(NumReq)) j = j - int'(NumReq);
            if (!valid_o && req_i[IdxW'(j)]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/refill_rd_arbiter.sv
// rtl/refill_rd_arbiter.sv - round-robin sharing of one axi_shim read port between refill requesters
module refill_rd_arbiter
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned AxiIdWidth = RdIdWidth,
    parameter int unsigned BlenWidth  = RdBlenWidth,
    localparam int unsigned IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0]                    req_rd_req_i,
    input  logic [NumReq-1:0][63:0]              req_rd_addr_i,
    input  logic [NumReq-1:0][BlenWidth-1:0]     req_rd_blen_i,
    input  logic [NumReq-1:0][1:0]               req_rd_size_i,
    input  logic [NumReq-1:0][AxiIdWidth-1:0]    req_rd_id_i,
    input  logic [NumReq-1:0]                    req_rd_rdy_i,
    output logic [NumReq-1:0]                    req_rd_gnt_o,
    output logic [NumReq-1:0]                    req_rd_valid_o,
    output logic [NumReq-1:0]                    req_rd_last_o,
    output logic [NumReq-1:0]                    req_rd_exokay_o,
    output logic [63:0]                          req_rd_data_o,
    output logic [AxiIdWidth-1:0]                req_rd_id_o,
    output logic                                 shim_rd_req_o,
    output logic [63:0]                          shim_rd_addr_o,
    output logic [BlenWidth-1:0]                 shim_rd_blen_o,
    output logic [1:0]                           shim_rd_size_o,
    output logic [AxiIdWidth-1:0]                shim_rd_id_o,
    output logic                                 shim_rd_lock_o,
    output logic                                 shim_rd_rdy_o,
    input  logic                                 shim_rd_gnt_i,
    input  logic                                 shim_rd_valid_i,
    input  logic                                 shim_rd_last_i,
    input  logic                                 shim_rd_exokay_i,
    input  logic [63:0]                          shim_rd_data_i,
    input  logic [AxiIdWidth-1:0]                shim_rd_id_i,
    output logic                                 busy_o,
    output logic [IdxW-1:0]                      owner_o,
    output logic                                 err_o
);

    localparam int unsigned CntW = BlenWidth + 1;

    refill_arb_state_e     state_q;
    logic [IdxW-1:0]       rr_ptr_q, owner_q, pick_idx, sel_idx;
    logic [AxiIdWidth-1:0] id_q;
    logic [BlenWidth-1:0]  blen_q;
    logic [CntW-1:0]       beat_cnt_q;
    logic                  err_q, err_d, pick_valid, beat_acc;
    rd_req_t               reqs [NumReq];
    rd_req_t               sel_req;

    refill_rr_pick #(.NumReq(NumReq)) u_pick (
        .req_i   (req_rd_req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            reqs[i].addr = req_rd_addr_i[i];
            reqs[i].blen = RdBlenWidth'(req_rd_blen_i[i]);
            reqs[i].size = req_rd_size_i[i];
            reqs[i].id   = RdIdWidth'(req_rd_id_i[i]);
        end
    end

    // Once a request is presented to the shim the AR payload must not change, so
    // arbitration only happens in IDLE; afterwards the latched owner drives it.
    assign sel_idx        = (state_q == ARB_IDLE) ? pick_idx : owner_q;
    assign sel_req        = reqs[sel_idx];
    assign shim_rd_req_o  = (state_q == ARB_IDLE) ? pick_valid : (state_q == ARB_ADDR);
    assign shim_rd_addr_o = sel_req.addr;
    assign shim_rd_blen_o = BlenWidth'(sel_req.blen);
    assign shim_rd_size_o = sel_req.size;
    assign shim_rd_id_o   = AxiIdWidth'(sel_req.id);
    assign shim_rd_lock_o = 1'b0;

    assign shim_rd_rdy_o  = (state_q == ARB_DATA) ? req_rd_rdy_i[owner_q] : 1'b1;
    assign beat_acc       = (state_q == ARB_DATA) && shim_rd_valid_i && shim_rd_rdy_o;
    assign req_rd_data_o  = shim_rd_data_i;
    assign req_rd_id_o    = shim_rd_id_i;

    always_comb begin
        req_rd_gnt_o    = '0;
        req_rd_valid_o  = '0;
        req_rd_last_o   = '0;
        req_rd_exokay_o = '0;
        if (shim_rd_req_o && shim_rd_gnt_i) req_rd_gnt_o[sel_idx] = 1'b1;
        if (beat_acc) begin
            req_rd_valid_o[owner_q]  = 1'b1;
            req_rd_last_o[owner_q]   = shim_rd_last_i;
            req_rd_exokay_o[owner_q] = shim_rd_exokay_i;
        end
    end

    always_comb begin
        err_d = 1'b0;
        if (state_q != ARB_DATA) begin
            err_d = shim_rd_valid_i;
        end else if (beat_acc) begin
            err_d = (shim_rd_id_i != id_q) ||
                    (shim_rd_last_i && (beat_cnt_q != {1'b0, blen_q}));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            id_q       <= '0;
            blen_q     <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner_q    <= pick_idx;
                        id_q       <= AxiIdWidth'(sel_req.id);
                        blen_q     <= BlenWidth'(sel_req.blen);
                        beat_cnt_q <= '0;
                        state_q    <= shim_rd_gnt_i ? ARB_DATA : ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (shim_rd_gnt_i) state_q <= ARB_DATA;
                end
                ARB_DATA: begin
                    if (beat_acc) begin
                        beat_cnt_q <= beat_cnt_q + CntW'(1);
                        if (shim_rd_last_i) begin
                            state_q  <= ARB_IDLE;
                            rr_ptr_q <= (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q != ARB_IDLE);
    assign owner_o = owner_q;
    assign err_o   = err_q;

endmodule

// File: doc/refill_rd_arbiter.md
# refill_rd_arbiter

Shares one `axi_shim` read port between `NumReq` refill requesters, such as the I-cache wrapper and the D-cache miss unit. It performs round-robin arbitration and holds the winner's address-phase request stable until the shim grants it. It then routes every read beat back to that owner until the burst's last beat. Only one burst is in flight at a time. The block sits between the cache refill logic and the `axi_shim` read-side ports.

## Interface
- `NumReq`, 2: number of requesters, ≥2.
- `AxiIdWidth`, 4: AXI ID width.
- `BlenWidth`, 3: burst-length field width, `$clog2(AxiNumWords)`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Asynchronous, active-high.
- `req_rd_req_i` in [NumReq]: per-requester read request. Held with payload until granted.
- `req_rd_addr_i` in [NumReq][64]: request address.
- `req_rd_blen_i` in [NumReq][BlenWidth]: beats−1.
- `req_rd_size_i` in [NumReq][2]: AXI size.
- `req_rd_id_i` in [NumReq][AxiIdWidth]: transaction ID.
- `req_rd_rdy_i` in [NumReq]: requester can accept a beat.
- `req_rd_gnt_o` out [NumReq]: one-hot grant pulse.
- `req_rd_valid_o`, `req_rd_last_o`, `req_rd_exokay_o` out [NumReq]: per-requester beat strobes.
- `req_rd_data_o` out 64: beat data, shared by all requesters, qualified by `req_rd_valid_o`.
- `req_rd_id_o` out AxiIdWidth: beat ID, shared by all requesters.
- `shim_rd_req_o` out 1: request to the shim.
- `shim_rd_addr_o` out 64, `shim_rd_blen_o` out BlenWidth, `shim_rd_size_o` out 2, `shim_rd_id_o` out AxiIdWidth: request payload to the shim.
- `shim_rd_lock_o` out 1: tied to 0.
- `shim_rd_rdy_o` out 1: beat acceptance to the shim.
- `shim_rd_gnt_i` in 1: shim grant.
- `shim_rd_valid_i`, `shim_rd_last_i`, `shim_rd_exokay_i` in 1: beat strobes from the shim.
- `shim_rd_data_i` in 64: beat data from the shim.
- `shim_rd_id_i` in AxiIdWidth: beat ID from the shim.
- `busy_o` out 1: state ≠ IDLE.
- `owner_o` out `$clog2(NumReq)`: current or last owner.
- `err_o` out 1: one-cycle protocol-error pulse.

## Operation
- The FSM has three states: IDLE, ADDR and DATA.
- **IDLE**
  - The winner is the first asserted `req_rd_req_i` at or after `rr_ptr`, searching upward and wrapping at `NumReq`.
  - `shim_rd_req_o = |req_rd_req_i`. The payload is the winner's, passed through combinationally.
  - `shim_rd_gnt_i` is forwarded only to the winner's `req_rd_gnt_o`.
  - `owner_q` and `id_q` latch the winner whenever any request is present.
  - If the winner is granted in the same cycle, go to DATA. If a request is present but not granted, go to ADDR.
- **ADDR**
  - `owner_q` is locked; there is no re-arbitration, because the AR channel must stay stable.
  - The payload comes from `owner_q`. A grant moves the FSM to DATA.
- **DATA**
  - `shim_rd_rdy_o = req_rd_rdy_i[owner_q]`.
  - An accepted beat is `shim_rd_valid_i & shim_rd_rdy_o`. It raises `req_rd_valid_o[owner_q]`, and `req_rd_last_o[owner_q]` when `last` is set.
  - `beat_cnt` (BlenWidth+1 bits) increments per accepted beat.
  - On the accepted last beat: go to IDLE and set `rr_ptr = owner_q+1`, wrapping `NumReq−1 → 0`.
- **Errors**: `err_o` pulses for any of these:
  - a beat arrives in IDLE or ADDR; the beat is dropped and `shim_rd_rdy_o` is 1;
  - `shim_rd_id_i ≠ id_q` in DATA; the beat is still routed to the owner;
  - the last beat arrives with `beat_cnt ≠ blen_q`.
- **Outside DATA**: `shim_rd_rdy_o = 1`, so stray beats are drained.
- **Reset values**: state IDLE, `rr_ptr = 0`, `owner_q = 0`, `id_q = 0`, `blen_q = 0`, `beat_cnt = 0`. With no requests, `shim_rd_req_o = 0`, all grants and valids are 0, `err_o = 0` and `busy_o = 0`.
- **Reset mid-burst**: the FSM returns to IDLE. Beats arriving afterwards are drained and flagged by `err_o`.

## Timing
- Request to `shim_rd_req_o`: 0 cycles, combinational, in IDLE.
- Grant to requester: same cycle as `shim_rd_gnt_i`.
- Beat routing: combinational, 0 cycles.
- Minimum gap from last beat to the next shim request: 1 cycle, because the FSM is in IDLE the following cycle.
- A new request arriving during DATA waits; the sequence is last beat → IDLE → arbitrate.
- When the last beat and a new request coincide, the new request is evaluated next cycle against the updated `rr_ptr`.
- `err_o` is registered and asserts the cycle after the offending beat.
- Requesters must hold `req_rd_req_i` and their payload until `req_rd_gnt_o`.

## Structure
- Put the state enum `refill_arb_state_e` and the struct `rd_req_t` (addr, blen, size, id) in `wt_cache_pkg`.
- Sub-module `refill_rr_pick` is the combinational first-set-from-pointer search, with parameter `NumReq`. It outputs the index and a valid flag.
- Everything else lives in one module.

## Test plan
- **Single request**: requester 0 sends addr `0x8000_0040`, blen 1, and the shim grants after 2 cycles. Required: `shim_rd_addr_o` stable for 3 cycles; `req_rd_gnt_o = 01` for 1 cycle; 2 beats routed to requester 0 only; `err_o` stays 0.
- **Fairness**: both requesters hold requests continuously, the shim grants immediately and bursts have blen 0. Required grant order 0,1,0,1 with `owner_o` toggling.
- **Back-pressure**: during a 4-beat burst, `req_rd_rdy_i[owner]` is low for 3 cycles. Required: `shim_rd_rdy_o` low for those cycles, `beat_cnt` frozen, and completion still at 4 accepted beats.
- **Errors**:
  - a stray beat in IDLE gives an `err_o` pulse and no `req_rd_valid_o`;
  - a wrong ID in DATA gives an `err_o` pulse with the beat still delivered;
  - `last` on beat 2 of blen 3 gives an `err_o` pulse and a return to IDLE.
- **Reset mid-burst**: assert `rst_i` after beat 1 of 4. Required: IDLE and all outputs at reset values; the remaining 3 beats are drained with `err_o` pulses; the next request is served normally starting from `rr_ptr = 0`.
